// File: rtl/approx_add_err_monitor.sv
// Streaming error-statistics monitor for an approximate signed adder.
// Optional sum-of-squared-error output is enabled by defining SQ_ERR_EN.
module approx_add_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        n_samples,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_a,
    input  logic signed [WIDTH-1:0] in_b,
    input  logic signed [WIDTH:0]   in_o,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH:0]          wce,
    output logic [ACC_W-1:0]        sae,
    output logic [CNT_W-1:0]        err_cnt,
    output logic [CNT_W-1:0]        smp_cnt
`ifdef SQ_ERR_EN
    ,
    output logic [ACC_W+WIDTH+1:0]  sse
`endif
);

    localparam int SQ_W  = 2 * (WIDTH + 1);
    localparam int SSE_W = ACC_W + WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [WIDTH:0] abs_err(input logic signed [WIDTH+1:0] e);
        logic signed [WIDTH+1:0] mag;
        mag = (e < 0) ? -e : e;
        return (WIDTH+1)'(mag);
    endfunction

    function automatic logic [ACC_W-1:0] sat_add_acc(input logic [ACC_W-1:0] acc,
                                                     input logic [WIDTH:0]   inc);
        logic [ACC_W:0] s;
        s = {1'b0, acc} + {{(ACC_W-WIDTH){1'b0}}, inc};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{CNT_W{1'b0}}, 1'b1};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         acc_q, acc_d, tgt_q, tgt_d;
    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [WIDTH+1:0]  err_p1_q, err_p1_d;
    logic [WIDTH:0]           abs_p2_q, abs_p2_d;
    logic [WIDTH:0]           wce_q, wce_d;
    logic [ACC_W-1:0]         sae_q, sae_d;
    logic [CNT_W-1:0]         err_cnt_q, err_cnt_d, smp_cnt_q, smp_cnt_d;
    logic                     start_ok, accept;
    logic signed [WIDTH:0]    exact;
    logic signed [WIDTH+1:0]  err_c;
`ifdef SQ_ERR_EN
    logic [SQ_W-1:0]          sq_p2_q, sq_p2_d;
    logic [SSE_W-1:0]         sse_q, sse_d;
    logic [SSE_W:0]           sse_sum;
`endif

    assign in_ready = (state_q == RUN) && (acc_q < tgt_q);
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        tgt_d    = tgt_q;
        vld_p1_d = accept;
        vld_p2_d = vld_p1_q;
        case (state_q)
            IDLE, DONE: if (start_ok) begin
                state_d = RUN;
                acc_d   = '0;
                tgt_d   = n_samples;
            end
            RUN: begin
                if (acc_q == tgt_q) state_d = DRAIN;
                if (accept) acc_d = acc_q + 1'b1;
            end
            DRAIN: if (!vld_p1_q && !vld_p2_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // stage 1: exact sum and signed error, captured only on acceptance
    always_comb begin
        exact    = (WIDTH+1)'(in_a) + (WIDTH+1)'(in_b);
        err_c    = (WIDTH+2)'(in_o) - (WIDTH+2)'(exact);
        err_p1_d = accept ? err_c : err_p1_q;
    end

    // stage 2: magnitude (and its square)
    always_comb begin
        abs_p2_d = abs_err(err_p1_q);
`ifdef SQ_ERR_EN
        sq_p2_d  = SQ_W'(abs_p2_d) * SQ_W'(abs_p2_d);
`endif
    end

    // statistics: cleared by an accepted start, updated from stage 2
    always_comb begin
        wce_d     = wce_q;
        sae_d     = sae_q;
        err_cnt_d = err_cnt_q;
        smp_cnt_d = smp_cnt_q;
`ifdef SQ_ERR_EN
        sse_d     = sse_q;
        sse_sum   = {1'b0, sse_q} + {{(SSE_W+1-SQ_W){1'b0}}, sq_p2_q};
`endif
        if (start_ok) begin
            wce_d     = '0;
            sae_d     = '0;
            err_cnt_d = '0;
            smp_cnt_d = '0;
`ifdef SQ_ERR_EN
            sse_d     = '0;
`endif
        end else if (vld_p2_q) begin
            if (abs_p2_q > wce_q) wce_d = abs_p2_q;
            sae_d     = sat_add_acc(sae_q, abs_p2_q);
            if (abs_p2_q != '0) err_cnt_d = sat_inc(err_cnt_q);
            smp_cnt_d = sat_inc(smp_cnt_q);
`ifdef SQ_ERR_EN
            sse_d     = sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            tgt_q     <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            wce_q     <= '0;
            sae_q     <= '0;
            err_cnt_q <= '0;
            smp_cnt_q <= '0;
`ifdef SQ_ERR_EN
            sse_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            tgt_q     <= tgt_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            wce_q     <= wce_d;
            sae_q     <= sae_d;
            err_cnt_q <= err_cnt_d;
            smp_cnt_q <= smp_cnt_d;
`ifdef SQ_ERR_EN
            sse_q     <= sse_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        err_p1_q <= err_p1_d;
        abs_p2_q <= abs_p2_d;
`ifdef SQ_ERR_EN
        sq_p2_q  <= sq_p2_d;
`endif
    end

    assign wce     = wce_q;
    assign sae     = sae_q;
    assign err_cnt = err_cnt_q;
    assign smp_cnt = smp_cnt_q;
`ifdef SQ_ERR_EN
    assign sse     = sse_q;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor: table of single-tuple runs plus
// multi-cycle sequences for backpressure, control and empty runs.
module tb_approx_add_err_monitor;

    logic               clk = 1'b0;
    logic               rst, start, in_valid, in_ready, busy, done;
    logic [31:0]        n_samples;
    logic signed [15:0] in_a, in_b;
    logic signed [16:0] in_o;
    logic [16:0]        wce;
    logic [47:0]        sae;
    logic [31:0]        err_cnt, smp_cnt;
`ifdef SQ_ERR_EN
    logic [65:0]        sse;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    approx_add_err_monitor dut (
        .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .busy(busy), .done(done), .wce(wce), .sae(sae),
        .err_cnt(err_cnt), .smp_cnt(smp_cnt)
`ifdef SQ_ERR_EN
        , .sse(sse)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [16:0] o;
        longint             wce;
        longint             sae;
        longint             errc;
        longint             sse;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] n);
        start     = 1'b1;
        n_samples = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic signed [16:0] o);
        in_a = a; in_b = b; in_o = o;
        in_valid = 1'b1;
        for (int k = 0; k < 10 && !in_ready; k++) tick();
        check("in_ready_before_send", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 20 && !done; k++) tick();
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("in_ready_in_done", in_ready, 0);
    endtask

    task automatic check_stats(input string tag, input longint e_wce, input longint e_sae,
                               input longint e_err, input longint e_smp, input longint e_sse);
        check({tag, ".wce"}, wce, e_wce);
        check({tag, ".sae"}, sae, e_sae);
        check({tag, ".err_cnt"}, err_cnt, e_err);
        check({tag, ".smp_cnt"}, smp_cnt, e_smp);
`ifdef SQ_ERR_EN
        check({tag, ".sse"}, sse, e_sse);
`else
        if (e_sse < 0) check({tag, ".sse_arg"}, 0, 1);
`endif
    endtask

    task automatic run_bp(input bit toggle, input int cycles);
        int  acc;
        bit  fire, seen_full;
        acc       = 0;
        seen_full = 0;
        do_start(4);
        for (int c = 0; c < cycles; c++) begin
            in_valid = toggle ? (c % 2 == 0) : 1'b1;
            in_a     = 16'(c);
            in_b     = 16'(3 * c);
            in_o     = 17'(4 * c + acc);
            fire     = in_valid && in_ready;
            tick();
            if (fire) acc++;
            if (acc == 4 && !seen_full) begin
                seen_full = 1;
                check(toggle ? "bp_tog.ready_after_4th" : "bp_hold.ready_after_4th", in_ready, 0);
            end
        end
        in_valid = 1'b0;
        check(toggle ? "bp_tog.accepted" : "bp_hold.accepted", acc, 4);
        wait_done();
        check_stats(toggle ? "bp_tog" : "bp_hold", 3, 6, 3, 4, 14);
    endtask

    initial begin
        vecs[0] = '{16'sd20,     16'sd10,     17'sd31,     1,      1,      1, 1};
        vecs[1] = '{-16'sd32768, -16'sd32768, 17'sd65535,  131071, 131071, 1, 64'd17179607041};
        vecs[2] = '{16'sd100,    -16'sd50,    17'sd40,     10,     10,     1, 100};
        vecs[3] = '{16'sd32767,  16'sd32767,  17'sd65534,  0,      0,      0, 0};
        vecs[4] = '{-16'sd1,     16'sd0,      -17'sd3,     2,      2,      1, 4};
        vecs[5] = '{-16'sd32768, -16'sd32768, -17'sd65536, 0,      0,      0, 0};
        vecs[6] = '{16'sd0,      16'sd0,      -17'sd65536, 65536,  65536,  1, 64'd4294967296};

        rst = 1'b1; start = 1'b0; n_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_o = '0;
        tick(); tick();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.in_ready", in_ready, 0);
        check_stats("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            do_start(1);
            send(vecs[i].a, vecs[i].b, vecs[i].o);
            wait_done();
            check_stats($sformatf("vec%0d", i), vecs[i].wce, vecs[i].sae, vecs[i].errc, 1, vecs[i].sse);
        end

        do_start(3);
        send(16'sd12831, 16'sd14873, 17'sd27704);
        send(-16'sd19937, 16'sd14873, -17'sd5064);
        send(16'sd0, 16'sd0, 17'sd1);
        wait_done();
        check_stats("n3", 1, 1, 1, 3, 1);

        run_bp(1'b0, 6);
        run_bp(1'b1, 12);

        // start during RUN must not retarget or clear
        do_start(5);
        send(16'sd1, 16'sd1, 17'sd3);
        do_start(1);
        check("ctl.busy_after_ignored_start", busy, 1);
        for (int i = 0; i < 4; i++) send(16'sd1, 16'sd1, 17'sd3);
        wait_done();
        check_stats("ctl", 1, 5, 5, 5, 5);

        // reset mid-run abandons everything
        do_start(5);
        send(16'sd1, 16'sd1, 17'sd3);
        send(16'sd2, 16'sd2, 17'sd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.in_ready", in_ready, 0);
        check_stats("midrst", 0, 0, 0, 0, 0);
        tick(); tick();
        check_stats("midrst_later", 0, 0, 0, 0, 0);
        do_start(1);
        send(vecs[2].a, vecs[2].b, vecs[2].o);
        wait_done();
        check_stats("after_rst", 10, 10, 1, 1, 100);

        // empty run
        begin
            bit saw_rdy;
            saw_rdy = 0;
            do_start(0);
            for (int i = 0; i < 3; i++) begin
                if (in_ready) saw_rdy = 1;
                tick();
            end
            check("n0.in_ready_seen", saw_rdy, 0);
            check("n0.done", done, 1);
            check_stats("n0", 0, 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Streaming checker at the output end of an approximate signed adder (add16se family).
- Accepts tuples (A, B, O_approx) over a valid/ready handshake and recomputes the exact signed sum.
- Accumulates error statistics over a programmed sample count: worst-case error, sum of absolute error, error count and sample count.
- Used in hardware characterization and in-system self-test of approximate adders.

Parameters:
- WIDTH, 16: operand width. O_approx is WIDTH+1 bits.
- CNT_W, 32: width of the sample-count and error-count registers.
- ACC_W, 48: width of the sum-of-absolute-error accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset. Interface is one clock; reset is synchronous and active-high.
- start  in  1  single-cycle pulse; clears statistics and begins a run.
- n_samples  in  CNT_W  number of tuples to accept; sampled on the start cycle.
- in_valid  in  1  tuple valid.
- in_ready  out  1  monitor can accept a tuple.
- in_a  in  WIDTH  operand A, signed.
- in_b  in  WIDTH  operand B, signed.
- in_o  in  WIDTH+1  approximate sum, signed.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE.
- wce  out  WIDTH+1  maximum |error| seen.
- sae  out  ACC_W  sum of |error|.
- err_cnt  out  CNT_W  number of tuples with error ≠ 0.
- smp_cnt  out  CNT_W  number of tuples accepted.

Behaviour:
- Reset: state IDLE. in_ready, busy and done are 0. wce, sae, err_cnt and smp_cnt are 0. Pipeline valids are cleared. Reset mid-run abandons the run; no partial results are kept.
- States:
  - IDLE –start→ RUN.
  - RUN –accepted count == target→ DRAIN.
  - DRAIN –pipeline empty→ DONE.
  - DONE –start→ RUN.
- start is ignored in RUN and DRAIN.
- On an accepted start: all statistics clear to 0 on the same edge, and target latches n_samples.
- n_samples == 0: RUN goes straight to DRAIN on the next cycle, then DONE. Statistics stay 0.
- in_ready = (state == RUN) && (accepted < target). It is registered-state derived and has no combinational path from in_valid.
- Acceptance happens on an edge with in_valid && in_ready. in_valid may drop at any time. Data are only sampled on acceptance.
- Pipeline stage 1, registered:
  - exact = sext(in_a) + sext(in_b), WIDTH+1 bits, never overflows.
  - err = sext(in_o) − sext(exact), WIDTH+2 bits.
- Pipeline stage 2, registered, updates statistics:
  - absErr = |err|, WIDTH+1 bits unsigned; maximum is 2^(WIDTH+1)−1.
  - wce = max(wce, absErr).
  - sae += absErr, saturating at all-ones.
  - err_cnt += (err ≠ 0).
  - smp_cnt += 1.
  - Counters saturate at all-ones.
- Latency: a tuple accepted at edge k is reflected in the statistics after edge k+2.
- Throughput: one tuple per cycle.
- DRAIN lasts until both stage valids are 0 (at most 2 cycles). done rises on the cycle after the last statistic update.
- In DONE, outputs hold until the next start or rst.

Optional Feature:
- Macro SQ_ERR_EN.
- Defined:
  - Adds output sse, ACC_W+WIDTH+2 bits: sum of absErr².
  - The square is computed in stage 2 with no extra latency.
  - sse saturates, clears on start and on rst.
- Undefined:
  - No sse port and no multiplier logic.
  - All other behaviour is identical.

Test Plan:
1. rst, then start with n=1, tuple a=20, b=10, o=31 → done; wce=1, sae=1, err_cnt=1, smp_cnt=1; sse=1 if enabled.
2. start with n=3, tuples:
   - (12831, 14873, 27704)
   - (−19937, 14873, −5064)
   - (0, 0, 1)

   Expected: wce=1, sae=1, err_cnt=1, smp_cnt=3.
3. Worst case: n=1, a=−32768, b=−32768, o=+65535 → wce=131071, sae=131071; sse=17179607041 if enabled.
4. Backpressure: n=4, in_valid held high for 6 cycles with distinct tuples → exactly 4 accepted; in_ready=0 from the cycle after the 4th acceptance; smp_cnt=4. Repeat with in_valid toggling every cycle → same counts.
5. Control: start pulsed during RUN → ignored and the target is unchanged. rst after 2 accepted samples → state IDLE, all outputs 0 on the next cycle. A new start then runs normally.
6. n=0 start → done=1 within 3 cycles; all statistics 0; in_ready never asserted.
